// File: rtl/tqvp_gera_gray_pkg.sv
// Shared definitions for the Gray sequencer peripheral.
// Holds the register address map, the CTRL bit positions and the
// sequencer state encoding. It has no ports.
package tqvp_gera_gray_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_START  = 4'h1;
  localparam logic [3:0] ADDR_END    = 4'h2;
  localparam logic [3:0] ADDR_DIV    = 4'h3;
  localparam logic [3:0] ADDR_CUR    = 4'h4;
  localparam logic [3:0] ADDR_OUT    = 4'h5;
  localparam logic [3:0] ADDR_STATUS = 4'h6;

  localparam int CTRL_START_CMD = 0;
  localparam int CTRL_STOP_CMD  = 1;
  localparam int CTRL_MODE      = 2;
  localparam int CTRL_CONT      = 3;
  localparam int CTRL_DIR       = 4;
  localparam int CTRL_EXT       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/tqvp_gera_gray_conv.sv
// Combinational Gray code converter.
//   i_mode  : 0 = binary -> Gray, 1 = Gray -> binary
//   i_value : value to convert
//   o_value : converted value
module tqvp_gera_gray_conv (
  input  logic       i_mode,
  input  logic [7:0] i_value,
  output logic [7:0] o_value
);

  logic [7:0] w_b2g;
  logic [7:0] w_g2b;

  assign w_b2g = i_value ^ (i_value >> 1);

  // Binary bit i is the XOR of Gray bits 7..i; written as a reduction of a
  // shifted copy so no bit depends on another bit of the same vector.
  always_comb begin
    w_g2b = '0;
    for (int i = 0; i < 8; i++) begin
      w_g2b[i] = ^(i_value >> i);
    end
  end

  assign o_value = i_mode ? w_g2b : w_b2g;

endmodule

// File: rtl/tqvp_gera_gray_seq.sv
// TinyQV byte peripheral: steps an 8-bit counter from START to END, either
// from an internal prescaler or on rising edges of ui_in[1], and drives the
// Gray-converted count onto uo_out.
//   clk, rst_n           : clock, asynchronous active-low reset
//   ui_in[7:0]           : input PMOD (ui_in[1] = external step)
//   uo_out[7:0]          : conv(CUR)
//   address[3:0]         : register address
//   data_write, data_in  : one-cycle write strobe and write data
//   data_out[7:0]        : combinational read data for address
// Bus handshake: a write takes effect on the clock edge where data_write is
// high; there is no backpressure, and reads are purely combinational.
// The sequencer state is visible as STATUS.busy (state != IDLE).
module tqvp_gera_gray_seq
  import tqvp_gera_gray_pkg::*;
#(
  parameter int DIV_W = 8  // must be 1..8, DIV is loaded from data_in
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_ctrl;       // stored CTRL bits 5:2 (ext, dir, cont, mode)
  logic [7:0]       r_start;
  logic [7:0]       r_end;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic [7:0]       r_cur;
  logic [7:0]       w_cur_nxt;
  logic             r_done;
  logic             w_done_set;
  logic             w_done_clr;
  logic             r_prev;

  logic w_mode, w_cont, w_dir, w_ext;
  logic w_wr_ctrl, w_cmd_start, w_cmd_stop, w_wr_status;
  logic w_tick;
  logic [7:0] w_out;
  logic w_unused;

  assign w_mode = r_ctrl[CTRL_MODE - 2];
  assign w_cont = r_ctrl[CTRL_CONT - 2];
  assign w_dir  = r_ctrl[CTRL_DIR - 2];
  assign w_ext  = r_ctrl[CTRL_EXT - 2];

  assign w_wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign w_cmd_start = w_wr_ctrl && data_in[CTRL_START_CMD];
  assign w_cmd_stop  = w_wr_ctrl && data_in[CTRL_STOP_CMD];
  assign w_wr_status = data_write && (address == ADDR_STATUS);

  assign w_tick = w_ext ? (ui_in[1] && !r_prev) : (r_div_cnt == '0);

  assign w_unused = &{1'b0, ui_in[7:2], ui_in[0]};

  tqvp_gera_gray_conv u_conv (
    .i_mode  (w_mode),
    .i_value (r_cur),
    .o_value (w_out)
  );

  assign uo_out = w_out;

  // Next-state logic. Stop beats start so a combined write is a no-op stop.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_div_cnt_nxt = r_div_cnt;
    w_done_set    = 1'b0;
    w_done_clr    = 1'b0;
    if (w_cmd_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cmd_start) begin
      w_state_nxt = ST_LOAD;
      w_done_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_LOAD: begin
          w_cur_nxt     = r_start;
          w_div_cnt_nxt = r_div;
          w_state_nxt   = ST_RUN;
        end
        ST_RUN: begin
          if (!w_ext) begin
            // DIV is re-read at every reload so rate changes apply live.
            w_div_cnt_nxt = (r_div_cnt == '0) ? r_div : (r_div_cnt - 1'b1);
          end
          if (w_tick) begin
            if (r_cur == r_end) begin
              if (w_cont) begin
                w_cur_nxt = r_start;
              end else begin
                w_state_nxt = ST_IDLE;
                w_done_set  = 1'b1;
              end
            end else begin
              w_cur_nxt = w_dir ? (r_cur - 1'b1) : (r_cur + 1'b1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_div_cnt <= '0;
      r_done    <= 1'b0;
      r_prev    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_prev    <= ui_in[1];
      // Completion is never lost to a simultaneous STATUS write.
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_done_clr || w_wr_status) begin
        r_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_div   <= '0;
    end else if (data_write) begin
      case (address)
        ADDR_CTRL:  r_ctrl  <= data_in[CTRL_EXT:CTRL_MODE];
        ADDR_START: r_start <= data_in;
        ADDR_END:   r_end   <= data_in;
        ADDR_DIV:   r_div   <= data_in[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:   data_out = {2'b00, r_ctrl, 2'b00};
      ADDR_START:  data_out = r_start;
      ADDR_END:    data_out = r_end;
      ADDR_DIV:    data_out = 8'(r_div);
      ADDR_CUR:    data_out = r_cur;
      ADDR_OUT:    data_out = w_out;
      ADDR_STATUS: data_out = {6'b0, r_done, (r_state != ST_IDLE)};
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_gera_gray_seq.sv
module tb_tqvp_gera_gray_seq;
  import tqvp_gera_gray_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_checks;
  int n_errors;

  tqvp_gera_gray_seq #(.DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Driver tasks: called at a falling edge, write lands on the next rising edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [7:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  logic [7:0] t1_exp [4];
  logic [7:0] t2_exp [4];
  logic [7:0] t4_exp [6];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    ui_in      = 8'h00;
    address    = 4'h0;
    data_write = 1'b0;
    data_in    = 8'h00;
    t1_exp = '{8'h02, 8'h06, 8'h07, 8'h05};
    t2_exp = '{8'h07, 8'h06, 8'h04, 8'h05};
    t4_exp = '{8'h01, 8'h00, 8'hFF, 8'hFE, 8'h01, 8'h00};

    // Reset values
    #2;
    check("rst_uo_out", uo_out, 8'h00);
    rd(ADDR_STATUS, "rst_status", 8'h00);
    rd(ADDR_CUR, "rst_cur", 8'h00);
    rd(ADDR_CTRL, "rst_ctrl", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // bin->gray, up, DIV=0: 3..6
    wr(ADDR_START, 8'h03);
    wr(ADDR_END, 8'h06);
    wr(ADDR_DIV, 8'h00);
    wr(ADDR_CTRL, 8'h01);
    rd(ADDR_STATUS, "t1_load_busy", 8'h01);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t1_uo_%0d", k), uo_out, t1_exp[k]);
    end
    @(negedge clk);
    rd(ADDR_STATUS, "t1_done", 8'h02);
    check("t1_uo_hold", uo_out, 8'h05);
    rd(ADDR_OUT, "t1_out_reg", 8'h05);
    rd(ADDR_CUR, "t1_cur_end", 8'h06);

    // gray->bin, DIV=2: 4..7 each held 3 cycles
    wr(ADDR_START, 8'h04);
    wr(ADDR_END, 8'h07);
    wr(ADDR_DIV, 8'h02);
    wr(ADDR_CTRL, 8'h05);
    rd(ADDR_STATUS, "t2_done_cleared", 8'h01);
    rd(ADDR_CTRL, "t2_ctrl_rd", 8'h04);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check($sformatf("t2_uo_%0d_%0d", k, c), uo_out, t2_exp[k]);
      end
    end
    @(negedge clk);
    rd(ADDR_STATUS, "t2_done", 8'h02);
    check("t2_uo_hold", uo_out, 8'h05);

    // STATUS write clears done
    wr(ADDR_STATUS, 8'h00);
    rd(ADDR_STATUS, "t3_done_clr", 8'h00);

    // Down, continuous, wrapping through 0
    wr(ADDR_START, 8'h01);
    wr(ADDR_END, 8'hFE);
    wr(ADDR_DIV, 8'h00);
    wr(ADDR_CTRL, 8'h19);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd(ADDR_CUR, $sformatf("t4_cur_%0d", k), t4_exp[k]);
    end
    rd(ADDR_STATUS, "t4_busy", 8'h01);
    wr(ADDR_CTRL, 8'h1A);
    rd(ADDR_CUR, "t4_stop_cur", 8'h00);
    rd(ADDR_STATUS, "t4_stop_status", 8'h00);
    @(negedge clk);
    rd(ADDR_CUR, "t4_stop_hold", 8'h00);

    // External step on ui_in[1] rising edges
    wr(ADDR_START, 8'h00);
    wr(ADDR_END, 8'h02);
    wr(ADDR_CTRL, 8'h21);
    @(negedge clk);
    rd(ADDR_CUR, "t5_start", 8'h00);
    ui_in = 8'h02;
    repeat (5) @(negedge clk);
    ui_in = 8'h00;
    rd(ADDR_CUR, "t5_long_pulse", 8'h01);
    repeat (3) @(negedge clk);
    rd(ADDR_CUR, "t5_gap", 8'h01);
    ui_in = 8'h02;
    @(negedge clk);
    ui_in = 8'h00;
    rd(ADDR_CUR, "t5_second", 8'h02);
    rd(ADDR_STATUS, "t5_busy", 8'h01);
    repeat (2) @(negedge clk);
    ui_in = 8'h02;
    @(negedge clk);
    ui_in = 8'h00;
    rd(ADDR_STATUS, "t5_done", 8'h02);
    rd(ADDR_CUR, "t5_cur_end", 8'h02);
    check("t5_uo", uo_out, 8'h03);
    rd(ADDR_CTRL, "t5_ctrl_rd", 8'h20);

    // Start and stop together in IDLE
    wr(ADDR_CTRL, 8'h03);
    rd(ADDR_STATUS, "t6_status", 8'h02);
    @(negedge clk);
    rd(ADDR_STATUS, "t6_status_later", 8'h02);
    rd(ADDR_CTRL, "t6_ctrl_rd", 8'h00);

    // Register readback and unmapped addresses
    wr(ADDR_DIV, 8'hA5);
    rd(ADDR_DIV, "t7_div_rd", 8'hA5);
    rd(ADDR_START, "t7_start_rd", 8'h00);
    rd(ADDR_END, "t7_end_rd", 8'h02);
    for (int a = 7; a < 16; a++) begin
      rd(4'(a), $sformatf("t7_unmapped_%0h", a), 8'h00);
    end

    // Asynchronous reset mid-run
    wr(ADDR_START, 8'h10);
    wr(ADDR_END, 8'h20);
    wr(ADDR_DIV, 8'h01);
    wr(ADDR_CTRL, 8'h01);
    repeat (5) @(negedge clk);
    rd(ADDR_CUR, "t8_cur_run", 8'h12);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    address = ADDR_CUR;
    #1;
    check("t8_rst_cur", data_out, 8'h00);
    check("t8_rst_uo", uo_out, 8'h00);
    address = ADDR_STATUS;
    #1;
    check("t8_rst_status", data_out, 8'h00);
    address = ADDR_DIV;
    #1;
    check("t8_rst_div", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
